// File: rtl/flag_channel_scheduler_pkg.sv
// flag_sched_pkg: shared state encoding and guard-counter sizing for the flag channel scheduler
package flag_sched_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   function automatic int guard_w(input int g);
      return (g > 2) ? $clog2(g) : 1;
   endfunction

endpackage

// File: rtl/flag_channel_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector, first set bit at or after ptr, wrapping modulo N
module rr_pick
   import flag_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [W:0] s;

   // scan from the farthest candidate back to ptr so the nearest pending index wins
   always_comb begin
      valid = |pending;
      idx = '0;
      s = '0;
      for (int i = N - 1; i >= 0; i--) begin
         s = {1'b0, ptr} + (W+1)'(i);
         s = (s >= (W+1)'(N)) ? s - (W+1)'(N) : s;
         idx = pending[s[W-1:0]] ? s[W-1:0] : idx;
      end
   end

endmodule

// File: rtl/flag_channel_scheduler.sv
// flag_channel_scheduler: round-robin sharing of one flag CDC channel among NREQ pulse requesters
module flag_channel_scheduler
   import flag_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int CODE_W = $clog2(NREQ),
   parameter int GUARD  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NREQ-1:0]   req,
   input  logic              clr_overflow,
   input  logic              sync_busy,
   output logic              sync_flag,
   output logic [CODE_W-1:0] chan_code,
   output logic [NREQ-1:0]   grant,
   output logic              done,
   output logic [NREQ-1:0]   pending,
   output logic [NREQ-1:0]   overflow
);

   localparam int GW = guard_w(GUARD);

   state_t            state;
   logic [CODE_W-1:0] ptr;
   logic [CODE_W-1:0] pick_idx;
   logic              pick_valid;
   logic [GW-1:0]     gcnt;

   rr_pick #(.N(NREQ), .W(CODE_W)) u_pick (
      .pending(pending),
      .ptr    (ptr),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   // issue/guard FSM; done is raised one cycle early so it lands on the cycle the count reaches GUARD-1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         chan_code <= '0;
         ptr       <= '0;
         gcnt      <= '0;
         sync_flag <= 1'b0;
         grant     <= '0;
         done      <= 1'b0;
      end else begin
         sync_flag <= 1'b0;
         grant     <= '0;
         done      <= 1'b0;
         case (state)
            IDLE: if (enable && pick_valid && !sync_busy) begin
               chan_code <= pick_idx;
               sync_flag <= 1'b1;
               grant     <= NREQ'(1) << pick_idx;
               state     <= ISSUE;
            end
            ISSUE: begin
               ptr   <= (chan_code == CODE_W'(NREQ - 1)) ? '0 : chan_code + CODE_W'(1);
               gcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               state <= done ? IDLE : WAIT;
               gcnt  <= sync_busy ? '0 : gcnt + GW'(1);
               done  <= !done && !sync_busy && (gcnt == GW'(GUARD - 2));
            end
            default: state <= IDLE;
         endcase
      end
   end

   // pending latch (set beats grant clear) and sticky overflow for coalesced requests
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         overflow <= '0;
      end else begin
         pending  <= (pending & ~grant) | req;
         overflow <= (clr_overflow ? '0 : overflow) | (req & pending & ~grant);
      end
   end

endmodule

// File: tb/tb_flag_channel_scheduler.sv
// tb_flag_channel_scheduler: table-driven vectors plus grant scoreboard and corner-case sequences
module tb_flag_channel_scheduler;

   localparam int NREQ = 4;
   localparam int CODE_W = 2;
   localparam int GUARD = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic              clr_overflow = 1'b0;
   logic              sync_busy = 1'b0;
   logic              sync_flag;
   logic [CODE_W-1:0] chan_code;
   logic [NREQ-1:0]   grant;
   logic              done;
   logic [NREQ-1:0]   pending;
   logic [NREQ-1:0]   overflow;

   flag_channel_scheduler #(.NREQ(NREQ), .CODE_W(CODE_W), .GUARD(GUARD)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req         (req),
      .clr_overflow(clr_overflow),
      .sync_busy   (sync_busy),
      .sync_flag   (sync_flag),
      .chan_code   (chan_code),
      .grant       (grant),
      .done        (done),
      .pending     (pending),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      int         n;
      logic [7:0] seq;
   } vec_t;

   vec_t       vecs[6];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [1:0] exp_q[$];
   logic [1:0] e_m;
   bit         timing_chk = 1'b1;
   bit         have_last = 1'b0;
   int         last_grant = 0;
   int         last_done = 0;
   int         ndone = 0;
   int         last_high = 0;
   logic [5:0] pat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (grant != '0) begin
            if (exp_q.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
            else begin
               e_m = exp_q.pop_front();
               check("grant", 32'(grant), 32'(4'b0001 << e_m));
               check("chan_code", 32'(chan_code), 32'(e_m));
               check("sync_flag", 32'(sync_flag), 32'd1);
               if (timing_chk && have_last) check("spacing", 32'(cyc - last_grant), 32'(GUARD + 2));
            end
            have_last = 1'b1;
            last_grant = cyc;
         end
         if (done) begin
            ndone++;
            last_done = cyc;
            if (timing_chk) check("done_lat", 32'(cyc - last_grant), 32'(GUARD));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req = '0;
      enable = 1'b1;
      clr_overflow = 1'b0;
      sync_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      have_last = 1'b0;
      ndone = 0;
      timing_chk = 1'b1;
      exp_q.delete();
   endtask

   task automatic pulse_req(input logic [3:0] r);
      req = r;
      tick();
      req = '0;
   endtask

   task automatic wait_grants(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("grants_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      vecs[0] = '{4'b0100, 1, 8'b00_00_00_10};
      vecs[1] = '{4'b1111, 4, 8'b11_10_01_00};
      vecs[2] = '{4'b1010, 2, 8'b00_00_11_01};
      vecs[3] = '{4'b1001, 2, 8'b00_00_11_00};
      vecs[4] = '{4'b0110, 2, 8'b00_00_10_01};
      vecs[5] = '{4'b1000, 1, 8'b00_00_00_11};

      do_reset();
      check("reset_outs", 32'({sync_flag, chan_code, grant, done, pending, overflow}), 32'd0);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].seq[2*k +: 2]);
         pulse_req(vecs[v].req);
         check("pending_latch", 32'(pending), 32'(vecs[v].req));
         wait_grants(vecs[v].n * 12 + 5);
         repeat (GUARD + 2) tick();
         check("done_count", 32'(ndone), 32'(vecs[v].n));
         check("pending_empty", 32'(pending), 32'd0);
         check("overflow_zero", 32'(overflow), 32'd0);
         check("code_hold", 32'(chan_code), 32'(vecs[v].seq[2*(vecs[v].n-1) +: 2]));
      end

      do_reset();
      timing_chk = 1'b0;
      exp_q.push_back(2'd1);
      pulse_req(4'b0010);
      wait_grants(10);
      pat = 6'b111101;
      for (int k = 0; k < 6; k++) begin
         sync_busy = pat[k];
         if (pat[k]) last_high = cyc;
         tick();
      end
      sync_busy = 1'b0;
      for (int n = 0; n < 20 && ndone == 0; n++) tick();
      check("busy_ndone", 32'(ndone), 32'd1);
      check("busy_done_lat", 32'(last_done - last_high), 32'(GUARD));

      do_reset();
      enable = 1'b0;
      req = 4'b0010;
      tick();
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      check("coal_pending", 32'(pending), 32'b0010);
      check("coal_overflow", 32'(overflow), 32'b0010);
      exp_q.push_back(2'd1);
      enable = 1'b1;
      wait_grants(10);
      repeat (25) tick();
      check("coal_pending_clr", 32'(pending), 32'd0);
      check("coal_ovf_sticky", 32'(overflow), 32'b0010);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("coal_ovf_clr", 32'(overflow), 32'd0);

      do_reset();
      exp_q.push_back(2'd0);
      pulse_req(4'b0001);
      wait_grants(10);
      pulse_req(4'b1000);
      tick();
      check("pre_rst_pending", 32'(pending), 32'b1000);
      #2 reset = 1'b1;
      #1 check("async_reset_outs", 32'({sync_flag, chan_code, grant, done, pending, overflow}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      have_last = 1'b0;
      ndone = 0;
      exp_q.delete();
      exp_q.push_back(2'd0);
      pulse_req(4'b0001);
      wait_grants(10);
      repeat (30) tick();
      check("rst_pending_lost", 32'(pending), 32'd0);

      do_reset();
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd0);
      req = 4'b0011;
      tick();
      req = '0;
      tick();
      req = 4'b0001;
      tick();
      req = '0;
      check("coll_pending", 32'(pending), 32'b0011);
      check("coll_overflow", 32'(overflow), 32'd0);
      wait_grants(40);
      repeat (GUARD + 2) tick();
      check("coll_pending_end", 32'(pending), 32'd0);
      check("coll_overflow_end", 32'(overflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
